// File: rtl/icetap_seg_capture_pkg.sv
// Shared definitions for the segmented capture block: FSM encoding and
// the per-signal condition codes used by the store and trigger matchers.
package icetap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] COND_DC   = 3'b000;
    localparam logic [2:0] COND_LOW  = 3'b001;
    localparam logic [2:0] COND_HIGH = 3'b010;
    localparam logic [2:0] COND_RISE = 3'b011;
    localparam logic [2:0] COND_FALL = 3'b100;
    localparam logic [2:0] COND_EDGE = 3'b101;

endpackage

// File: rtl/icetap_seg_capture_if.sv
// Control, status and readback bundle of the segmented capture block.
// The slave side belongs to the capture core, the master side to its host.
interface icetap_seg_capture_if #(
    parameter int NR_SIGNALS   = 16,
    parameter int RECORD_DEPTH = 256,
    parameter int NR_SEGMENTS  = 4
) ();
    localparam int SEG_DEPTH = RECORD_DEPTH / NR_SEGMENTS;
    localparam int AW        = $clog2(RECORD_DEPTH);
    localparam int SW        = $clog2(SEG_DEPTH);
    localparam int GW        = (NR_SEGMENTS > 1) ? $clog2(NR_SEGMENTS) : 1;

    logic [NR_SIGNALS-1:0]   signals_in;
    logic [3*NR_SIGNALS-1:0] store_mask_vec;
    logic [3*NR_SIGNALS-1:0] trigger_mask_vec;
    logic                    store_always;
    logic                    trigger_always;
    logic [SW-1:0]           pre_trigger_cnt;
    logic                    start;
    logic                    abort;
    logic [2:0]              state;
    logic [GW-1:0]           cur_segment;
    logic [NR_SEGMENTS-1:0]  seg_valid;
    logic [GW-1:0]           seg_sel;
    logic [AW-1:0]           seg_start_addr;
    logic [AW-1:0]           seg_trigger_addr;
    logic [AW-1:0]           seg_stop_addr;
    logic                    rd_req;
    logic [AW-1:0]           rd_addr;
    logic                    rd_valid;
    logic [NR_SIGNALS-1:0]   rd_data;

    modport master (
        output signals_in, store_mask_vec, trigger_mask_vec, store_always,
               trigger_always, pre_trigger_cnt, start, abort, seg_sel,
               rd_req, rd_addr,
        input  state, cur_segment, seg_valid, seg_start_addr,
               seg_trigger_addr, seg_stop_addr, rd_valid, rd_data
    );

    modport slave (
        input  signals_in, store_mask_vec, trigger_mask_vec, store_always,
               trigger_always, pre_trigger_cnt, start, abort, seg_sel,
               rd_req, rd_addr,
        output state, cur_segment, seg_valid, seg_start_addr,
               seg_trigger_addr, seg_stop_addr, rd_valid, rd_data
    );

endinterface

// File: rtl/icetap_seg_capture_cond_match.sv
// Evaluates a 3-bit condition code per probed signal against the current
// and previous sample, then ANDs all signals into a single match flag.
module icetap_cond_match
    import icetap_pkg::*;
#(
    parameter int NR_SIGNALS = 16
) (
    input  logic [NR_SIGNALS-1:0]   i_sig,
    input  logic [NR_SIGNALS-1:0]   i_prev,
    input  logic [3*NR_SIGNALS-1:0] i_mask_vec,
    input  logic                    i_always,
    output logic                    o_match
);

    logic [NR_SIGNALS-1:0] w_bit_ok;

    generate
        for (genvar gi = 0; gi < NR_SIGNALS; gi++) begin : g_bit
            logic [2:0] w_code;
            assign w_code = i_mask_vec[3*gi +: 3];
            // Codes 000, 110 and 111 fall through to don't-care.
            assign w_bit_ok[gi] =
                (w_code == COND_LOW)  ? ~i_sig[gi] :
                (w_code == COND_HIGH) ?  i_sig[gi] :
                (w_code == COND_RISE) ? ( i_sig[gi] & ~i_prev[gi]) :
                (w_code == COND_FALL) ? (~i_sig[gi] &  i_prev[gi]) :
                (w_code == COND_EDGE) ? ( i_sig[gi] ^  i_prev[gi]) :
                                        1'b1;
        end
    endgenerate

    assign o_match = i_always | (&w_bit_ok);

endmodule

// File: rtl/icetap_seg_capture.sv
// Segmented logic-analyser capture core: records NR_SEGMENTS trigger-centred
// windows into one block RAM and offers per-segment status plus readback.
module icetap_seg_capture
    import icetap_pkg::*;
#(
    parameter int NR_SIGNALS   = 16,
    parameter int RECORD_DEPTH = 256,
    parameter int NR_SEGMENTS  = 4
) (
    input  logic                src_clk,
    input  logic                src_reset_,
    icetap_seg_capture_if.slave bus
);

    localparam int SEG_DEPTH = RECORD_DEPTH / NR_SEGMENTS;
    localparam int AW        = $clog2(RECORD_DEPTH);
    localparam int SW        = $clog2(SEG_DEPTH);
    localparam int GW        = (NR_SEGMENTS > 1) ? $clog2(NR_SEGMENTS) : 1;
    localparam logic [AW-1:0] SEG_MASK = AW'(SEG_DEPTH - 1);

    state_t                r_state;
    logic [GW-1:0]         r_cur_seg;
    logic [NR_SEGMENTS-1:0] r_seg_valid;
    logic [NR_SIGNALS-1:0] r_prev;
    logic [AW-1:0]         r_wptr;
    logic [SW:0]           r_cnt;
    logic [SW-1:0]         r_pre;
    logic [AW-1:0]         r_start_addr [NR_SEGMENTS];
    logic [AW-1:0]         r_trig_addr  [NR_SEGMENTS];
    logic [AW-1:0]         r_stop_addr  [NR_SEGMENTS];
    logic [AW-1:0]         r_sel_start;
    logic [AW-1:0]         r_sel_trig;
    logic [AW-1:0]         r_sel_stop;
    logic                  r_rd_valid;
    logic [NR_SIGNALS-1:0] r_ram_q;
    logic [NR_SIGNALS-1:0] r_mem [RECORD_DEPTH];

    logic          w_store;
    logic          w_trig;
    logic          w_capturing;
    logic          w_we;
    logic          w_seg_done;
    logic          w_last_seg;
    logic          w_rd_ok;
    logic [SW:0]   w_cnt_inc;
    logic [SW:0]   w_post_cnt;
    logic [AW-1:0] w_wptr_inc;
    logic [AW-1:0] w_trig_now;
    logic [AW-1:0] w_start_calc;
    logic [AW-1:0] w_next_base;

    icetap_cond_match #(.NR_SIGNALS(NR_SIGNALS)) u_store_match (
        .i_sig      (bus.signals_in),
        .i_prev     (r_prev),
        .i_mask_vec (bus.store_mask_vec),
        .i_always   (bus.store_always),
        .o_match    (w_store)
    );

    icetap_cond_match #(.NR_SIGNALS(NR_SIGNALS)) u_trig_match (
        .i_sig      (bus.signals_in),
        .i_prev     (r_prev),
        .i_mask_vec (bus.trigger_mask_vec),
        .i_always   (bus.trigger_always),
        .o_match    (w_trig)
    );

    assign w_capturing = (r_state == ST_PRE) || (r_state == ST_ARMED) || (r_state == ST_POST);
    // An SW-bit pre-trigger count can never exceed SEG_DEPTH-1, so no clamp is needed.
    assign w_post_cnt  = (SW+1)'(SEG_DEPTH - 1) - {1'b0, r_pre};
    assign w_cnt_inc   = r_cnt + (SW+1)'(1);
    assign w_we        = w_capturing && !bus.abort &&
                         (w_store || ((r_state == ST_ARMED) && w_trig));
    assign w_wptr_inc  = (r_wptr & ~SEG_MASK) | ((r_wptr + AW'(1)) & SEG_MASK);
    assign w_trig_now  = (r_state == ST_ARMED) ? r_wptr : r_trig_addr[r_cur_seg];
    assign w_start_calc = (w_trig_now & ~SEG_MASK) | ((w_trig_now - AW'(r_pre)) & SEG_MASK);
    assign w_next_base = (AW'(r_cur_seg) + AW'(1)) << SW;
    assign w_last_seg  = (r_cur_seg == GW'(NR_SEGMENTS - 1));
    assign w_seg_done  = !bus.abort &&
                         (((r_state == ST_ARMED) && w_trig && (w_post_cnt == '0)) ||
                          ((r_state == ST_POST) && w_store && (w_cnt_inc == w_post_cnt)));
    assign w_rd_ok     = bus.rd_req && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge src_clk or negedge src_reset_) begin
        if (!src_reset_) begin
            r_state     <= ST_IDLE;
            r_cur_seg   <= '0;
            r_seg_valid <= '0;
            r_prev      <= '0;
            r_wptr      <= '0;
            r_cnt       <= '0;
            r_pre       <= '0;
            r_sel_start <= '0;
            r_sel_trig  <= '0;
            r_sel_stop  <= '0;
            r_rd_valid  <= 1'b0;
            for (int i = 0; i < NR_SEGMENTS; i++) begin
                r_start_addr[i] <= '0;
                r_trig_addr[i]  <= '0;
                r_stop_addr[i]  <= '0;
            end
        end else begin
            if (w_capturing) r_prev <= bus.signals_in;
            if (w_we)        r_wptr <= w_wptr_inc;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start && !bus.abort) begin
                        r_seg_valid <= '0;
                        r_cur_seg   <= '0;
                        r_wptr      <= '0;
                        r_cnt       <= '0;
                        r_pre       <= bus.pre_trigger_cnt;
                        r_prev      <= bus.signals_in;
                        r_state     <= (bus.pre_trigger_cnt == '0) ? ST_ARMED : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_store) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == {1'b0, r_pre}) begin
                            r_state <= ST_ARMED;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_ARMED: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_trig) begin
                        r_trig_addr[r_cur_seg] <= r_wptr;
                        r_cnt   <= '0;
                        r_state <= ST_POST;
                    end
                end
                ST_POST: begin
                    if (bus.abort)    r_state <= ST_IDLE;
                    else if (w_store) r_cnt   <= w_cnt_inc;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Segment completion overrides the per-state pointer/state updates above.
            if (w_seg_done) begin
                r_seg_valid[r_cur_seg]  <= 1'b1;
                r_start_addr[r_cur_seg] <= w_start_calc;
                r_stop_addr[r_cur_seg]  <= r_wptr;
                if (w_last_seg) begin
                    r_state <= ST_DONE;
                end else begin
                    r_cur_seg <= r_cur_seg + GW'(1);
                    r_wptr    <= w_next_base;
                    r_cnt     <= '0;
                    r_state   <= (r_pre == '0) ? ST_ARMED : ST_PRE;
                end
            end

            r_sel_start <= r_start_addr[bus.seg_sel];
            r_sel_trig  <= r_trig_addr[bus.seg_sel];
            r_sel_stop  <= r_stop_addr[bus.seg_sel];
            r_rd_valid  <= w_rd_ok;
        end
    end

    // Sample RAM kept free of reset so it maps onto a single block RAM.
    always_ff @(posedge src_clk) begin
        if (w_we)    r_mem[r_wptr] <= bus.signals_in;
        if (w_rd_ok) r_ram_q       <= r_mem[bus.rd_addr];
    end

    assign bus.state            = r_state;
    assign bus.cur_segment      = r_cur_seg;
    assign bus.seg_valid        = r_seg_valid;
    assign bus.seg_start_addr   = r_sel_start;
    assign bus.seg_trigger_addr = r_sel_trig;
    assign bus.seg_stop_addr    = r_sel_stop;
    assign bus.rd_valid         = r_rd_valid;
    assign bus.rd_data          = r_rd_valid ? r_ram_q : '0;

endmodule

// File: tb/tb_icetap_seg_capture.sv
// Scoreboarded bench for the segmented capture core: full runs, edge trigger,
// zero post count, abort, readback gating and reset during capture.
module tb_icetap_seg_capture;
    import icetap_pkg::*;

    localparam int NS = 16;
    localparam int RD = 256;
    localparam int NSEG = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icetap_seg_capture_if #(.NR_SIGNALS(NS), .RECORD_DEPTH(RD), .NR_SEGMENTS(NSEG)) bus ();

    icetap_seg_capture #(.NR_SIGNALS(NS), .RECORD_DEPTH(RD), .NR_SEGMENTS(NSEG)) dut (
        .src_clk    (clk),
        .src_reset_ (rst_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [NS-1:0] exp_mem [RD];
    logic [NS-1:0] sb_q [$];
    logic rd_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; any readback response is matched against the scoreboard.
    task automatic tick();
        logic was_req;
        logic [NS-1:0] d;
        was_req = bus.rd_req;
        @(posedge clk);
        #1;
        if (was_req || bus.rd_valid) begin
            check("rd_valid", 32'(bus.rd_valid), 32'(rd_exp));
            if (bus.rd_valid && sb_q.size() > 0) begin
                d = sb_q.pop_front();
                check("rd_data", 32'(bus.rd_data), 32'(d));
                $display("readback data=%h expected=%h", bus.rd_data, d);
            end
        end
        rd_exp = 1'b0;
    endtask

    task automatic put(input logic [NS-1:0] data, input int addr);
        bus.signals_in = data;
        exp_mem[addr] = data;
        tick();
    endtask

    task automatic rd_issue(input int addr, input logic expect_ok);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 8'(addr);
        if (expect_ok) begin
            sb_q.push_back(exp_mem[addr]);
            rd_exp = 1'b1;
        end
        tick();
        bus.rd_req = 1'b0;
    endtask

    task automatic do_start(input int pre, input logic st_always, input logic tr_always);
        bus.store_always    = st_always;
        bus.trigger_always  = tr_always;
        bus.pre_trigger_cnt = 6'(pre);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic status(input string tag, input int seg, input int s, input int t, input int p);
        bus.seg_sel = 2'(seg);
        tick();
        check({tag, "_start"}, 32'(bus.seg_start_addr), 32'(s));
        check({tag, "_trig"},  32'(bus.seg_trigger_addr), 32'(t));
        check({tag, "_stop"},  32'(bus.seg_stop_addr), 32'(p));
    endtask

    // Store and trigger always true, pre=10: every cycle writes the next address.
    task automatic run_full(input int seed);
        bus.store_mask_vec   = '0;
        bus.trigger_mask_vec = '0;
        do_start(10, 1'b1, 1'b1);
        check("full_pre", 32'(bus.state), 32'(ST_PRE));
        for (int k = 0; k < 256; k++) begin
            put(NS'(k * 37 + seed), k);
            if (k == 9)  check("full_armed", 32'(bus.state), 32'(ST_ARMED));
            if (k == 10) check("full_post", 32'(bus.state), 32'(ST_POST));
            if (k == 63) check("full_seg1", 32'({bus.cur_segment, bus.state}), 32'({2'd1, ST_PRE}));
        end
        check("full_done", 32'(bus.state), 32'(ST_DONE));
        check("full_valid", 32'(bus.seg_valid), 32'h0000000f);
        status("full_seg0", 0, 0, 10, 63);
        status("full_seg3", 3, 192, 202, 255);
    endtask

    initial begin
        bus.signals_in = '0; bus.store_mask_vec = '0; bus.trigger_mask_vec = '0;
        bus.store_always = 1'b0; bus.trigger_always = 1'b0; bus.pre_trigger_cnt = '0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.seg_sel = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(bus.state), 32'(ST_IDLE));
        check("rst_valid", 32'(bus.seg_valid), 0);
        check("rst_rd", 32'({bus.rd_valid, bus.rd_data}), 0);
        rst_n = 1'b1;
        tick();

        // Full four-segment run, then readback in DONE.
        run_full(5);
        rd_issue(10, 1'b1);
        rd_issue(0, 1'b1);
        rd_issue(202, 1'b1);
        rd_issue(255, 1'b1);

        // Abort while segment 2 is armed; the trigger cycle must not be written.
        run_full(1000);
        do_start(10, 1'b1, 1'b1);
        for (int k = 0; k < 138; k++) put(NS'(k * 91 + 7), k);
        check("abort_armed", 32'(bus.state), 32'(ST_ARMED));
        bus.signals_in = 16'hdead;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_idle", 32'(bus.state), 32'(ST_IDLE));
        check("abort_valid", 32'(bus.seg_valid), 32'h00000003);
        status("abort_seg0", 0, 0, 10, 63);
        status("abort_seg1", 1, 64, 74, 127);
        rd_issue(138, 1'b1);
        rd_issue(137, 1'b1);

        // Rising edge trigger on bit0 after 20 armed cycles, pre=5.
        bus.store_mask_vec = '0;
        bus.trigger_mask_vec = '0;
        bus.trigger_mask_vec[2:0] = COND_RISE;
        bus.signals_in = '0;
        do_start(5, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) put({15'(n * 11 + 3), 1'b0}, n % 64);
        check("edge_armed", 32'(bus.state), 32'(ST_ARMED));
        for (int n = 5; n < 25; n++) begin
            if (n == 15) begin
                bus.rd_req = 1'b1;
                bus.rd_addr = 8'd10;
            end
            put({15'(n * 11 + 3), 1'b0}, n % 64);
            bus.rd_req = 1'b0;
        end
        check("edge_wait", 32'(bus.state), 32'(ST_ARMED));
        put({15'(25 * 11 + 3), 1'b1}, 25);
        check("edge_post", 32'(bus.state), 32'(ST_POST));
        for (int n = 26; n < 84; n++) begin
            put({15'(n * 11 + 3), 1'b1}, n % 64);
            if (n == 82) check("edge_post_end", 32'(bus.state), 32'(ST_POST));
        end
        check("edge_next", 32'({bus.cur_segment, bus.state}), 32'({2'd1, ST_PRE}));
        check("edge_valid", 32'(bus.seg_valid), 32'h00000001);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("edge_idle", 32'(bus.state), 32'(ST_IDLE));
        status("edge_seg0", 0, 20, 25, 19);
        rd_issue(25, 1'b1);
        rd_issue(19, 1'b1);
        rd_issue(20, 1'b1);

        // pre=63 leaves no post samples: the trigger cycle ends the segment.
        bus.trigger_mask_vec = '0;
        bus.signals_in = '0;
        do_start(63, 1'b1, 1'b1);
        for (int n = 0; n < 63; n++) put(NS'(n + 16'h3000), n);
        check("p63_armed", 32'(bus.state), 32'(ST_ARMED));
        put(16'h3fff, 63);
        check("p63_next", 32'({bus.cur_segment, bus.state}), 32'({2'd1, ST_PRE}));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("p63_valid", 32'(bus.seg_valid), 32'h00000001);
        status("p63_seg0", 0, 0, 63, 63);
        rd_issue(63, 1'b1);

        // Asynchronous reset while in POST, then a clean full run.
        do_start(10, 1'b1, 1'b1);
        for (int n = 0; n < 20; n++) put(NS'(n + 16'h4000), n);
        check("rst_post", 32'(bus.state), 32'(ST_POST));
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'({bus.state, bus.cur_segment}), 0);
        check("arst_valid", 32'(bus.seg_valid), 0);
        check("arst_addr", 32'({bus.seg_start_addr, bus.seg_trigger_addr, bus.seg_stop_addr}), 0);
        check("arst_rd", 32'({bus.rd_valid, bus.rd_data}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_full(77);
        rd_issue(10, 1'b1);
        rd_issue(64, 1'b1);

        check("sb_empty", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
